// File: rtl/uart_show_tx.sv
// uart_show_tx: 8N1 UART transmitter that sends a latched multi-byte show
// buffer (byte 0 first, each byte LSB first) and pulses done at the end.
module uart_show_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_BYTES    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] tx_show,
  input  logic [4:0]   show_len,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LEN_CAP   = 5'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [127:0]  payload;
  logic [4:0]    len;
  logic [3:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud;

  logic [4:0] req_len;
  logic       baud_wrap;
  logic [2:0] bit_next;
  logic       last_byte;

  // Clamp the requested length to the buffer capacity.
  assign req_len   = (show_len > LEN_CAP) ? LEN_CAP : show_len;
  assign baud_wrap = (baud == BAUD_LAST);
  assign bit_next  = bit_idx + 3'd1;
  // len is at least 1 whenever we are outside IDLE, so len-1 cannot underflow.
  assign last_byte = ({1'b0, byte_idx} >= (len - 5'd1));

  // Frame sequencer: all outputs are registered so tx never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      payload  <= '0;
      len      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          baud <= '0;
          if (start) begin
            payload  <= tx_show;
            len      <= req_len;
            byte_idx <= '0;
            bit_idx  <= '0;
            if (req_len != 5'd0) begin
              state <= START;
              tx    <= 1'b0;
              busy  <= 1'b1;
            end else begin
              // Empty request completes immediately without touching the line.
              done <= 1'b1;
            end
          end
        end

        START: begin
          if (baud_wrap) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= payload[{byte_idx, 3'd0}];
          end else begin
            baud <= baud + CW'(1);
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_next;
              tx      <= payload[{byte_idx, bit_next}];
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end

        STOP: begin
          if (baud_wrap) begin
            baud <= '0;
            if (!last_byte) begin
              // Next start bit follows the stop bit with no idle gap.
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_show_tx.sv
// tb_uart_show_tx: directed bench for uart_show_tx with a short bit period.
module tb_uart_show_tx;
  localparam int CPB = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] tx_show;
  logic [4:0]   show_len;
  logic         tx;
  logic         busy;
  logic         done;

  int pass_cnt = 0;
  int total    = 0;

  uart_show_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_show  (tx_show),
    .show_len (show_len),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
  endtask

  // Checks nslots bit periods of one frame cycle by cycle, starting in the
  // first cycle of its start bit; decodes the byte at mid-bit like a receiver.
  task automatic check_frame(input logic [7:0] b, input int nslots, input string tag);
    logic [7:0] rx;
    logic       e;
    rx = '0;
    for (int s = 0; s < nslots; s++) begin
      if (s == 0)      e = 1'b0;
      else if (s == 9) e = 1'b1;
      else             e = b[s-1];
      for (int c = 0; c < CPB; c++) begin
        chk1({tag, ".tx"}, tx, e);
        chk1({tag, ".busy"}, busy, 1'b1);
        chk1({tag, ".done"}, done, 1'b0);
        if (c == CPB / 2 && s >= 1 && s <= 8) rx[s-1] = tx;
        tick();
      end
    end
    if (nslots == 10) begin
      chk8({tag, ".rx"}, rx, b);
      $display("[%0t] %s byte sent=%02h decoded=%02h", $time, tag, b, rx);
    end
  endtask

  task automatic check_done(input string tag);
    chk1({tag, ".done_pulse"}, done, 1'b1);
    chk1({tag, ".busy_low"}, busy, 1'b0);
    chk1({tag, ".tx_high"}, tx, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk1({tag, ".done"}, done, 1'b0);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".tx"}, tx, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    tx_show  = '0;
    show_len = '0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b1;
    tick();
    check_idle("post_reset");

    // 1: single byte 0x55
    tx_show  = '0;
    tx_show[7:0] = 8'h55;
    show_len = 5'd1;
    pulse_start();
    check_frame(8'h55, 10, "t1");
    check_done("t1");
    tick();
    check_idle("t1_after");
    $display("[%0t] transfer t1 len=1 complete", $time);

    // 2: "ABC" back-to-back bytes
    tx_show  = '0;
    tx_show[23:0] = 24'h434241;
    show_len = 5'd3;
    pulse_start();
    check_frame(8'h41, 10, "t2b0");
    check_frame(8'h42, 10, "t2b1");
    check_frame(8'h43, 10, "t2b2");
    check_done("t2");
    tick();
    check_idle("t2_after");
    $display("[%0t] transfer t2 len=3 complete", $time);

    // 3: zero-length request
    show_len = 5'd0;
    pulse_start();
    check_done("t3");
    tick();
    check_idle("t3_after");
    $display("[%0t] transfer t3 len=0 complete", $time);

    // 4: over-long request is clamped to 16 bytes
    for (int k = 0; k < 16; k++) tx_show[8*k +: 8] = 8'(k);
    show_len = 5'd20;
    pulse_start();
    for (int k = 0; k < 16; k++) check_frame(8'(k), 10, $sformatf("t4b%0d", k));
    check_done("t4");
    tick();
    check_idle("t4_after");
    $display("[%0t] transfer t4 len=20 clamped complete", $time);

    // 5: start/payload changes mid-transfer are ignored; async reset in DATA
    tx_show  = '0;
    tx_show[15:0] = 16'h3CA5;
    show_len = 5'd2;
    pulse_start();
    start    = 1'b1;
    tx_show  = {128{1'b1}};
    show_len = 5'd5;
    check_frame(8'hA5, 10, "t5b0");
    start = 1'b0;
    check_frame(8'h3C, 6, "t5b1");
    #2 reset = 1'b0;
    #1;
    check_idle("t5_async_reset");
    #1 reset = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      chk1("t5_quiet.tx", tx, 1'b1);
      chk1("t5_quiet.busy", busy, 1'b0);
      tick();
    end
    $display("[%0t] transfer t5 aborted by reset", $time);

    // 6: start held high repeats transfers with one idle cycle between
    tx_show  = '0;
    tx_show[7:0] = 8'hC3;
    show_len = 5'd1;
    start    = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      check_frame(8'hC3, 10, $sformatf("t6r%0d", r));
      check_done($sformatf("t6r%0d", r));
      if (r == 2) start = 1'b0;
      tick();
    end
    check_idle("t6_after");
    $display("[%0t] transfer t6 repeated x3 complete", $time);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
